// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I data-memory access stage.
// It checks each access for unsupported or misaligned forms, runs a req/ack
// bus transfer with byte-lane masks, and extends load data for write-back.
// The core is stalled until the access commits with a one-cycle done pulse.
module load_store_unit #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  fun3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        done,
   output logic [1:0]  err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_UNSUP    = 2'b11;

   // Last counter value before the access is abandoned (unused when TIMEOUT is 0).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        fun3_q, fun3_d;
   logic [1:0]        off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       load_data_q, load_data_d;
   logic [1:0]        err_q, err_d;

   logic              unsup;
   logic              misal;
   logic [3:0]        st_mask;
   logic [31:0]       st_wdata;
   logic [7:0]        lane_byte [4];
   logic [7:0]        sel_byte;
   logic [15:0]       sel_half;
   logic [31:0]       ext_data;

   // Split the read word into its four byte lanes.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = mem_rdata[8*gi +: 8];
   end

   // Classify the incoming access: unsupported forms first, then alignment.
   always_comb begin
      unsup = 1'b0;
      misal = 1'b0;
      if (load && store) begin
         unsup = 1'b1;
      end else if (store && !(fun3 inside {3'b000, 3'b001, 3'b010})) begin
         unsup = 1'b1;
      end else if (load && (fun3 inside {3'b011, 3'b110, 3'b111})) begin
         unsup = 1'b1;
      end
      if (fun3[1:0] == 2'b01 && addr[0]) begin
         misal = 1'b1;
      end else if (fun3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
         misal = 1'b1;
      end
   end

   // Store lane replication and byte-enable generation from size and offset.
   always_comb begin
      st_mask  = 4'b0000;
      st_wdata = store_data;
      case (fun3[1:0])
         2'b00: begin
            st_wdata = {4{store_data[7:0]}};
            st_mask  = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{store_data[15:0]}};
            st_mask  = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = store_data;
            st_mask  = 4'b1111;
         end
      endcase
      if (!store) begin
         st_mask = 4'b0000;
      end
   end

   // Select and extend the loaded lane using the offset latched at request time.
   always_comb begin
      sel_byte = lane_byte[off_q];
      sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (fun3_q)
         3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
         3'b100:  ext_data = {24'd0, sel_byte};
         3'b101:  ext_data = {16'd0, sel_half};
         default: ext_data = mem_rdata;
      endcase
   end

   // Next-state logic and stall generation for the IDLE/REQ/DONE sequence.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wmask_d     = wmask_q;
      wdata_d     = wdata_q;
      fun3_d      = fun3_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      err_d       = err_q;
      stall       = 1'b0;
      case (state_q)
         S_IDLE: begin
            err_d = ERR_NONE;
            if (load || store) begin
               stall = 1'b1;
               if (unsup) begin
                  state_d = S_DONE;
                  err_d   = ERR_UNSUP;
               end else if (misal) begin
                  state_d = S_DONE;
                  err_d   = ERR_MISALIGN;
               end else begin
                  state_d = S_REQ;
                  we_d    = store;
                  addr_d  = {addr[31:2], 2'b00};
                  wmask_d = st_mask;
                  wdata_d = st_wdata;
                  fun3_d  = fun3;
                  off_d   = addr[1:0];
                  cnt_d   = '0;
               end
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (mem_ack) begin
               state_d = S_DONE;
               err_d   = ERR_NONE;
               if (!we_q) begin
                  load_data_d = ext_data;
               end
            end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
               state_d     = S_DONE;
               err_d       = ERR_TIMEOUT;
               load_data_d = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            // Inputs here belong to the committing instruction; ignore them.
            state_d = S_IDLE;
            err_d   = ERR_NONE;
         end
         default: begin
            state_d = S_IDLE;
            err_d   = ERR_NONE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wmask_q     <= '0;
         wdata_q     <= '0;
         fun3_q      <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         load_data_q <= '0;
         err_q       <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wmask_q     <= wmask_d;
         wdata_q     <= wdata_d;
         fun3_q      <= fun3_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
      end
   end

   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wmask = wmask_q;
   assign mem_wdata = wdata_q;
   assign load_data = load_data_q;
   assign done      = (state_q == S_DONE);
   assign err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses checked
// against a transaction-level model of expected bus fields, timing and results.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        store = 1'b0;
   logic [2:0]  fun3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] load_data;
   logic        stall;
   logic        done;
   logic [1:0]  err;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model_ld = 32'd0;

   load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .store      (store),
      .fun3       (fun3),
      .addr       (addr),
      .store_data (store_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wmask  (mem_wmask),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .load_data  (load_data),
      .stall      (stall),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int access_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Architectural fault class of an access: 0 ok, 1 misaligned, 3 unsupported.
   function automatic int classify(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
      if (ld && st) return 3;
      if (st && f3 > 3'd2) return 3;
      if (ld && (f3 == 3'd3 || f3 >= 3'd6)) return 3;
      if ((a % access_size(f3)) != 0) return 1;
      return 0;
   endfunction

   // Load result by plain arithmetic on the read word.
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      int unsigned b;
      int unsigned h;
      int          v;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
      case (f3)
         3'd0: begin v = (b >= 128) ? int'(b) - 256 : int'(b); return 32'(v); end
         3'd1: begin v = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(v); end
         3'd4: return 32'(b);
         3'd5: return 32'(h);
         default: return w;
      endcase
   endfunction

   // One access; waits = REQ cycles without ack before the ack (>= TO means none).
   task automatic run_txn(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input int waits,
                          input logic [31:0] rword);
      int          e;
      int          size;
      int          done_cyc;
      int          exp_req;
      int          req_n;
      int          stall_n;
      int          cyc;
      bit          got;
      logic [3:0]  emask;
      logic [31:0] ewd;
      logic [31:0] eld;
      e     = classify(ld, st, f3, a);
      size  = access_size(f3);
      emask = st ? 4'(((1 << size) - 1) << int'(a[1:0])) : 4'd0;
      for (int i = 0; i < 4; i++) ewd[8*i +: 8] = sd[8*(i % size) +: 8];
      if (e != 0) begin
         done_cyc = 1; exp_req = 0; eld = model_ld;
      end else if (waits < TO) begin
         done_cyc = waits + 2; exp_req = waits + 1;
         eld = ld ? extend(f3, a[1:0], rword) : model_ld;
      end else begin
         done_cyc = TO + 1; exp_req = TO; eld = 32'd0; e = 2;
      end
      load = ld; store = st; fun3 = f3; addr = a; store_data = sd;
      cyc = 0; got = 0; req_n = 0; stall_n = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            check_eq({nm, ".err"}, 32'(err), 32'(e));
            check_eq({nm, ".load_data"}, load_data, eld);
            check_eq({nm, ".done_cycle"}, cyc, done_cyc);
            check_eq({nm, ".stall_in_done"}, 32'(stall), 32'd0);
            check_eq({nm, ".stall_cycles"}, stall_n, done_cyc);
            check_eq({nm, ".req_cycles"}, req_n, exp_req);
            if (e == 2) begin
               mem_ack = 1'b1;
               mem_rdata = $urandom;
            end
         end else begin
            if (stall) stall_n++;
            if (mem_req) begin
               req_n++;
               check_eq({nm, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
               check_eq({nm, ".mem_we"}, 32'(mem_we), 32'(st));
               check_eq({nm, ".mem_wmask"}, 32'(mem_wmask), 32'(emask));
               if (st) check_eq({nm, ".mem_wdata"}, mem_wdata, ewd);
               mem_ack = (req_n - 1 == waits);
               mem_rdata = mem_ack ? rword : $urandom;
            end
         end
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (cyc == 0) begin
            // Scramble inputs after the access is accepted: must not matter.
            load = 1'($urandom); store = 1'($urandom); fun3 = 3'($urandom);
            addr = $urandom; store_data = $urandom;
         end
         cyc++;
      end
      if (!got) check_eq({nm, ".done_seen"}, 32'd0, 32'd1);
      load = 1'b0; store = 1'b0;
      model_ld = eld;
      $display("txn %s ld=%0d st=%0d f3=%0d addr=%h waits=%0d err=%0d load_data=%h",
               nm, ld, st, f3, a, waits, err, load_data);
   endtask

   // Reset in the second REQ cycle of a load: access abandoned without done.
   task automatic reset_mid_req();
      load = 1'b1; fun3 = 3'd2; addr = 32'h500;
      @(negedge clk);
      check_eq("rst.stall_c0", 32'(stall), 32'd1);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      check_eq("rst.req_c1", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rst.req_c2", 32'(mem_req), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst.req_after", 32'(mem_req), 32'd0);
      check_eq("rst.done_after", 32'(done), 32'd0);
      check_eq("rst.stall_after", 32'(stall), 32'd0);
      check_eq("rst.load_data", load_data, 32'd0);
      check_eq("rst.mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      check_eq("rst.done_later", 32'(done), 32'd0);
      @(posedge clk); #1;
      model_ld = 32'd0;
      $display("txn reset_mid_req done=%0d mem_req=%0d", done, mem_req);
   endtask

   initial begin
      bit          rl;
      bit          rs;
      int          pick;
      logic [2:0]  rf;
      logic [31:0] ra;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset.mem_req", 32'(mem_req), 32'd0);
      check_eq("reset.mem_we", 32'(mem_we), 32'd0);
      check_eq("reset.mem_addr", mem_addr, 32'd0);
      check_eq("reset.mem_wmask", 32'(mem_wmask), 32'd0);
      check_eq("reset.mem_wdata", mem_wdata, 32'd0);
      check_eq("reset.load_data", load_data, 32'd0);
      check_eq("reset.done", 32'(done), 32'd0);
      check_eq("reset.err", 32'(err), 32'd0);
      check_eq("reset.stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_txn("sw",      0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'd0);
      run_txn("sb",      0, 1, 3'd0, 32'h103, 32'h000000A5, 1, 32'd0);
      run_txn("sh",      0, 1, 3'd1, 32'h102, 32'h00001234, 0, 32'd0);
      run_txn("lb",      1, 0, 3'd0, 32'h201, 32'h0,        3, 32'h000080FF);
      run_txn("lbu",     1, 0, 3'd4, 32'h201, 32'h0,        3, 32'h000080FF);
      run_txn("sw_keep", 0, 1, 3'd2, 32'h104, 32'h11223344, 0, 32'd0);
      run_txn("lw_mis",  1, 0, 3'd2, 32'h102, 32'h0,        0, 32'd0);
      run_txn("ldst",    1, 1, 3'd2, 32'h100, 32'h0,        0, 32'd0);
      run_txn("ld_f6",   1, 0, 3'd6, 32'h100, 32'h0,        0, 32'd0);
      run_txn("sh_mis",  0, 1, 3'd1, 32'h101, 32'h5555,     0, 32'd0);
      run_txn("lh",      1, 0, 3'd1, 32'h202, 32'h0,        1, 32'h9ABC1234);
      run_txn("lhu",     1, 0, 3'd5, 32'h202, 32'h0,        2, 32'h9ABC1234);
      run_txn("lw_to",   1, 0, 3'd2, 32'h400, 32'h0,        9, 32'd0);
      reset_mid_req();
      run_txn("lw_post", 1, 0, 3'd2, 32'h300, 32'h0,        0, 32'hCAFEF00D);

      for (int n = 0; n < 250; n++) begin
         pick = $urandom_range(0, 19);
         rl = (pick < 9) || (pick >= 18);
         rs = (pick >= 9);
         rf = 3'($urandom_range(0, 7));
         ra = $urandom & 32'h0000_FFFF;
         run_txn("rnd", rl, rs, rf, ra, $urandom, $urandom_range(0, 5), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage directly downstream of the control decoder in the RV32I core.
- Consumes the decoded Load/Store strobes, fun3, the ALU-computed effective address and rs2 data.
- Drives a req/ack memory bus with byte-lane masks, returns sign/zero-extended load data for write-back, and stalls the core until the access completes.
- Flags misaligned, unsupported and timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles in REQ waiting for mem_ack before aborting; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  decoded load strobe.
store  input  1  decoded store strobe.
fun3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
addr  input  32  effective byte address from the ALU.
store_data  input  32  rs2 value.
mem_req  output  1  bus request, held until ack or abort.
mem_we  output  1  1 = write, 0 = read.
mem_addr  output  32  word address, {addr[31:2],2'b00}.
mem_wmask  output  4  byte-lane write enables.
mem_wdata  output  32  lane-replicated write data.
mem_ack  input  1  bus completion; single-cycle pulse.
mem_rdata  input  32  read word; valid when mem_ack=1.
load_data  output  32  extended load result, registered.
stall  output  1  holds PC/pipeline while an access is pending.
done  output  1  one-cycle pulse in the cycle the access commits.
err  output  2  cause, valid with done: 00 none, 01 misaligned, 10 timeout, 11 unsupported.

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset sends the FSM to IDLE and clears all of the following: mem_req, mem_we, mem_addr, mem_wmask, mem_wdata, load_data, done, err, and the counter.
- stall is combinational: 1 when (IDLE & (load|store)) or REQ; 0 in DONE and in idle cycles with no request.
- IDLE, with load|store asserted:
  - Unsupported if load&store are both high, if store with fun3 ∉ {000,001,010}, or if load with fun3 ∈ {011,110,111}. Next state DONE with err=11.
  - Misaligned if h/hu with addr[0]=1, or w with addr[1:0]≠00. Next state DONE with err=01.
  - Otherwise next state REQ. On the transition, register mem_addr, mem_we=store, mem_wmask, mem_wdata, fun3 and addr[1:0], and clear the counter.
- Store lanes (o = addr[1:0]):
  - sb: wdata = {4{sd[7:0]}}, wmask = 4'b0001<<o.
  - sh: wdata = {2{sd[15:0]}}, wmask = o[1] ? 1100 : 0011.
  - sw: wdata = sd, wmask = 1111.
  - Loads: wmask = 0000.
- REQ:
  - mem_req = 1. All bus outputs stay stable regardless of input changes.
  - mem_ack=1 → DONE, err=00. For a load, load_data <= extension of the lane selected by the latched offset: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the full word.
  - No ack: counter increments. When the counter == TIMEOUT-1 and no ack arrives (TIMEOUT≠0) → DONE, err=10, load_data <= 0.
  - mem_req deasserts on the edge leaving REQ.
- DONE:
  - done=1 and err holds the registered cause; stall=0, so the core commits at this edge.
  - Unconditional next state is IDLE. Inputs present during DONE belong to the committing instruction and are ignored.
  - done and err clear to 0 in IDLE.
- Latency:
  - Zero-wait-state bus (ack in the first REQ cycle): strobe at cycle 0 → done at cycle 2, i.e. 2 stall cycles.
  - Faults: done at cycle 1.
- load_data holds its value until the next load completes; stores and faults other than timeout leave it unchanged.
- mem_ack outside REQ is ignored, including a late ack arriving after a timeout.
- rst asserted in any state returns to IDLE on that edge: mem_req=0 on the next cycle, and no done pulse is produced for the aborted access.
- The counter saturates and never wraps; it is only compared while in REQ.

Test Plan:
- sw addr=0x100, sd=0xDEADBEEF, ack on the first REQ cycle → mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF, mem_we=1; stall high for 2 cycles; done at cycle 2 with err=00.
- sb addr=0x103, sd=0x000000A5 → wmask=1000, wdata=0xA5A5A5A5. sh addr=0x102, sd=0x1234 → wmask=1100, wdata=0x12341234.
- lb then lbu at addr=0x201, mem_rdata=0x0000_80FF, ack after 3 wait cycles → load_data=0xFFFFFF80, then 0x00000080; stall held the full 5 cycles each.
- lw addr=0x102 → no mem_req, done at cycle 1 with err=01. load&store both high → err=11. Load with fun3=110 → err=11.
- TIMEOUT=4 with no ack → mem_req high exactly 4 cycles, then done with err=10 and load_data=0; an ack arriving one cycle later is ignored.
- rst pulsed in the 2nd REQ cycle → IDLE and mem_req=0 next cycle, no done; a following lw addr=0x300 with ack completes normally.
